// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: MDOp codes,
// FSM state codes and the divide-by-zero quotient pattern.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Quotient written on divide by zero; sliced to the datapath width.
  localparam logic [63:0] DIVZERO_LO = '1;

  // Operations that run through the multi-cycle datapath.
  function automatic logic is_arith(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative radix-2 datapath: one shared 2*W register holding either the
// multiply accumulator {hi, lo} or the divide state {remainder, quotient}.
// load captures magnitudes; each step advances one bit.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic                    step,
  input  logic                    div_mode,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] acc
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] acc_reg, acc_next;
  logic [W-1:0]   b_reg;
  logic           div_reg;
  logic [W:0]     mul_sum;
  logic [W:0]     div_shifted;
  logic [W:0]     div_diff;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum     = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, b_reg} : '0);
    div_shifted = acc_reg[2*W-1:W-1];
    div_diff    = div_shifted - {1'b0, b_reg};
    acc_next    = {mul_sum, acc_reg[W-1:1]};
    if (div_reg) begin
      if (!div_diff[W])
        acc_next = {div_diff[W-1:0], acc_reg[W-2:0], 1'b1};
      else
        acc_next = {div_shifted[W-1:0], acc_reg[W-2:0], 1'b0};
    end
  end

  // Operand capture on load, one bit of progress per step.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_reg <= '0;
      b_reg   <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= {{W{1'b0}}, a};
      b_reg   <= b;
      div_reg <= div_mode;
    end else if (step) begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// MIPS HI/LO multiply/divide controller: IDLE -> CALC (DATA_WIDTH iterations)
// -> FIX (sign correction, HI/LO commit). MTHI/MTLO write directly in IDLE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier
// and go IDLE -> FIX directly; divides are unaffected.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [2:0]            MDOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivZero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W = DATA_WIDTH;

  logic [1:0]           state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 busy_reg, done_reg, dz_reg;
  logic [W-1:0]         hi_reg, lo_reg, a_raw_reg;
  logic                 neg_lo_reg, neg_hi_reg, div_reg, bzero_reg;

  logic           op_arith, op_div, op_signed, accept, core_step;
  logic [W-1:0]   a_abs, b_abs, hi_fix, lo_fix;
  logic [2*W-1:0] acc, prod_fix;

`ifdef MULDIV_FAST_MUL_EN
  logic           fast_reg;
  logic [2*W-1:0] fast_prod_reg, ext_a, ext_b;
  assign ext_a = op_signed ? {{W{SrcA[W-1]}}, SrcA} : {{W{1'b0}}, SrcA};
  assign ext_b = op_signed ? {{W{SrcB[W-1]}}, SrcB} : {{W{1'b0}}, SrcB};
`endif

  assign op_arith  = is_arith(MDOp);
  assign op_div    = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
  assign op_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
  assign accept    = (state_reg == ST_IDLE) && Start && !Flush;
  assign core_step = (state_reg == ST_CALC) && !Flush;
  assign a_abs     = (op_signed && SrcA[W-1]) ? -SrcA : SrcA;
  assign b_abs     = (op_signed && SrcB[W-1]) ? -SrcB : SrcB;

  muldiv_iter_core #(.DATA_WIDTH(W)) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept && op_arith),
    .step     (core_step),
    .div_mode (op_div),
    .a        (a_abs),
    .b        (b_abs),
    .acc      (acc)
  );

  // Sign-corrected results presented to HI/LO at the commit edge.
  always_comb begin
    prod_fix = neg_lo_reg ? -acc : acc;
    hi_fix   = prod_fix[2*W-1:W];
    lo_fix   = prod_fix[W-1:0];
`ifdef MULDIV_FAST_MUL_EN
    if (fast_reg) begin
      hi_fix = fast_prod_reg[2*W-1:W];
      lo_fix = fast_prod_reg[W-1:0];
    end
`endif
    if (div_reg) begin
      if (bzero_reg) begin
        hi_fix = a_raw_reg;
        lo_fix = DIVZERO_LO[W-1:0];
      end else begin
        hi_fix = neg_hi_reg ? -acc[2*W-1:W] : acc[2*W-1:W];
        lo_fix = neg_lo_reg ? -acc[W-1:0] : acc[W-1:0];
      end
    end
  end

  // Control FSM, sign flags and architectural HI/LO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      a_raw_reg  <= '0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      div_reg    <= 1'b0;
      bzero_reg  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fast_reg      <= 1'b0;
      fast_prod_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op_arith) begin
              a_raw_reg  <= SrcA;
              div_reg    <= op_div;
              bzero_reg  <= (SrcB == '0);
              neg_lo_reg <= op_signed & (SrcA[W-1] ^ SrcB[W-1]);
              neg_hi_reg <= op_signed & SrcA[W-1];
              cnt_reg    <= '0;
              busy_reg   <= 1'b1;
              dz_reg     <= 1'b0;
              state_reg  <= ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
              fast_reg      <= !op_div;
              fast_prod_reg <= ext_a * ext_b;
              if (!op_div)
                state_reg <= ST_FIX;
`endif
            end else if (MDOp == MD_MTHI) begin
              hi_reg <= SrcA;
            end else if (MDOp == MD_MTLO) begin
              lo_reg <= SrcA;
            end
          end
        end
        ST_CALC: begin
          if (Flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            if (cnt_reg == CNT_WIDTH'(W - 1))
              state_reg <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (Flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hi_reg    <= hi_fix;
            lo_reg    <= lo_fix;
            dz_reg    <= div_reg & bzero_reg;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Done    = done_reg;
  assign DivZero = dz_reg;
  assign HI      = hi_reg;
  assign LO      = lo_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: stimulus pushes the expected HI/LO,
// DivZero and Done cycle; a monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_ctrl;

  logic        CLK, RST, Start, Flush;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done, DivZero;
  logic [31:0] HI, LO;

  localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  hilo_muldiv_ctrl dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MDOp(MDOp), .SrcA(SrcA),
    .SrcB(SrcB), .Flush(Flush), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b1 && Done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", Done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn %s: HI=%h LO=%h DivZero=%b cyc=%0d", e.name, HI, LO, DivZero, cyc);
        chk({e.name, "_hi"},  HI,      e.hi);
        chk({e.name, "_lo"},  LO,      e.lo);
        chk({e.name, "_dz"},  DivZero, e.dz);
        chk({e.name, "_cyc"}, cyc,     e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int lat, input string nm);
    exp_t e;
    @(negedge CLK);
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + 1 + lat; e.name = nm;
      sb.push_back(e);
    end
    $display("issue %s op=%b a=%h b=%h", nm, op, a, b);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK);
      if (Done) begin seen = 1; break; end
    end
    if (!seen) chk({nm, "_timeout"}, Done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; Start = 1'b0; Flush = 1'b0; MDOp = 3'b000; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge CLK);
    chk("rst_hi", HI, 0); chk("rst_lo", LO, 0); chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0); chk("rst_dz", DivZero, 0);
    RST = 1'b1;

    issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, MUL_LAT, "mult_m3x7");
    if (MUL_LAT > 1) chk("mult_busy", Busy, 1);
    wait_done("mult_m3x7");

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, MUL_LAT, "multu_max");
    wait_done("multu_max");

    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, DIV_LAT, "div_m7d2");
    chk("div_busy", Busy, 1);
    wait_done("div_m7d2");

    issue(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, DIV_LAT, "divu_100d7");
    wait_done("divu_100d7");

    issue(3'b011, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1, DIV_LAT, "divu_5d0");
    wait_done("divu_5d0");

    // MTLO leaves DivZero and HI alone, no Busy.
    issue(3'b101, 32'h0000_ABCD, 32'd0, 0, 0, 0, 0, 0, "mtlo");
    chk("mtlo_lo", LO, 32'h0000_ABCD); chk("mtlo_dz", DivZero, 1);
    chk("mtlo_hi", HI, 32'd5);         chk("mtlo_busy", Busy, 0);

    issue(3'b100, 32'h1234_5678, 32'd0, 0, 0, 0, 0, 0, "mthi");
    chk("mthi_hi", HI, 32'h1234_5678); chk("mthi_busy", Busy, 0);

    // Overflow divide; a Start issued mid-operation must be ignored.
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 0, DIV_LAT, "div_ovf");
    chk("div_ovf_dzclr", DivZero, 0);
    repeat (5) @(negedge CLK);
    Start = 1'b1; MDOp = 3'b001; SrcA = 32'd3; SrcB = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    chk("div_ovf_busy", Busy, 1);
    wait_done("div_ovf");

    issue(3'b010, 32'hFFFF_FFF7, 32'd0, 1, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1, DIV_LAT, "div_m9d0");
    wait_done("div_m9d0");

    // Flush mid-CALC: Busy drops next edge, HI/LO untouched, no Done.
    issue(3'b011, 32'd100, 32'd7, 0, 0, 0, 0, 0, "divu_flush");
    repeat (9) @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    chk("flush_busy", Busy, 0);
    repeat (40) @(negedge CLK);
    chk("flush_hi", HI, 32'hFFFF_FFF7); chk("flush_lo", LO, 32'hFFFF_FFFF);
    chk("flush_dz", DivZero, 0);

    // Flush and Start together in IDLE: request dropped.
    @(negedge CLK);
    Start = 1'b1; Flush = 1'b1; MDOp = 3'b100; SrcA = 32'hDEAD_BEEF;
    @(negedge CLK);
    MDOp = 3'b011; SrcA = 32'd9; SrcB = 32'd2;
    @(negedge CLK);
    Start = 1'b0; Flush = 1'b0;
    chk("flushstart_hi", HI, 32'hFFFF_FFF7); chk("flushstart_busy", Busy, 0);
    $display("txn flush_start: HI=%h Busy=%b", HI, Busy);

    // Asynchronous reset mid-CALC.
    issue(3'b011, 32'd1000, 32'd3, 0, 0, 0, 0, 0, "divu_rst");
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("arst_hi", HI, 0); chk("arst_lo", LO, 0); chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0); chk("arst_dz", DivZero, 0);
    $display("txn async_reset: HI=%h LO=%h Busy=%b", HI, LO, Busy);
    @(negedge CLK);
    RST = 1'b1;

    issue(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, DIV_LAT, "divu_after_rst");
    wait_done("divu_after_rst");
    repeat (2) @(negedge CLK);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequences the MIPS multiply/divide group (MULT, MULTU, DIV, DIVU, MTHI, MTLO) as a multi-cycle unit beside the ALU.
- Owns the architectural HI/LO registers, which the ALU does not hold.
- The multi-cycle control FSM issues one operation, stalls on Busy, then reads HI/LO through MFHI/MFLO.
- Single requester. Internal iterative radix-2 datapath; no combinational 64-bit divider.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- MDOp  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
- SrcA  in  DATA_WIDTH  rs operand (multiplicand/dividend/move source).
- SrcB  in  DATA_WIDTH  rt operand (multiplier/divisor).
- Flush  in  1  abort in-flight operation (exception).
- Busy  out  1  registered; high while an operation is in flight.
- Done  out  1  registered one-cycle pulse when HI/LO are committed by MULT/DIV.
- DivZero  out  1  registered; set by divide with SrcB==0, held until next accepted Start.
- HI  out  DATA_WIDTH  architectural HI.
- LO  out  DATA_WIDTH  architectural LO.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0, counter=0, internal operand registers 0.
- States:
  - IDLE: wait for Start.
  - CALC: DATA_WIDTH iterations.
  - FIX: sign correction and commit.
- IDLE, Start=1, MDOp=MULT/MULTU/DIV/DIVU:
  - At the sampling edge k, latch |SrcA| and |SrcB| for signed ops and raw values for unsigned ops.
  - Latch the result sign flags (product sign = A^B; quotient sign = A^B; remainder sign = sign of A).
  - Counter=0, Busy<=1, DivZero<=0, state->CALC.
- IDLE, Start=1, MDOp=MTHI/MTLO: HI or LO <= SrcA at that edge. No Busy, no Done, stay IDLE.
- IDLE, Start=1, reserved MDOp: no effect.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After DATA_WIDTH iterations (edge k+32 at default), state->FIX.
- FIX, at edge k+33:
  - Negate results per the sign flags.
  - Write {HI,LO} = product, or HI=remainder, LO=quotient.
  - Busy<=0, Done<=1 for one cycle, state->IDLE.
- Total latency: Start edge to commit edge is 33 cycles. Done is visible during the cycle after commit. HI/LO hold their old values until the commit edge.
- Divide by zero:
  - Completes with normal latency.
  - Result: HI = dividend (SrcA as issued), LO = all ones.
  - DivZero<=1 at commit edge.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- Start while Busy: ignored, not queued. The requester must wait for Done.
- Flush while CALC/FIX: state->IDLE and Busy<=0 next edge; HI/LO unchanged; no Done.
- Flush and Start together in IDLE: Flush wins; request dropped.
- RST low mid-operation: immediate return to reset values, including HI/LO.

Optional Feature:
- MULDIV_FAST_MUL_EN:
  - When defined, MULT/MULTU bypass CALC. The product is computed with a single-cycle DATA_WIDTH×DATA_WIDTH multiplier; state goes IDLE->FIX, commits at edge k+1, Done one cycle later.
  - Divides are unchanged.
  - When undefined, the multiply uses the iterative 33-cycle path and no hardware multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - MDOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - FSM state encodings (ST_IDLE, ST_CALC, ST_FIX).
  - DIVZERO_LO constant (all ones).
- One sub-module, muldiv_iter_core: the accumulator/remainder shift registers and add/subtract step, driven by the FSM's load/step strobes.
- The FSM, sign handling and HI/LO registers stay in the top.

Test Plan:
- MULT SrcA=-3 (0xFFFFFFFD), SrcB=7 -> Busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done one pulse. With MULDIV_FAST_MUL_EN: commit at edge k+1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF, DivZero=1. Next MTLO clears nothing. Next accepted DIV clears DivZero at its Start edge.
- MTHI 0x12345678 in IDLE -> HI updated next edge, Busy stays 0. A Start issued mid-DIV is ignored, and HI/LO reflect only the DIV.
- DIV started, Flush at iteration 10 -> Busy falls next edge, no Done, HI/LO keep prior values. RST low mid-CALC -> all outputs 0 asynchronously.
